// File: rtl/surf_debug_pkg.sv
// surf_debug_pkg: shared debug word width and capture state encoding.
package surf_debug_pkg;

    localparam int DBG_WIDTH = 35;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        POST,
        DONE
    } cap_state_e;

endpackage

// File: rtl/surf_debug_capture_ram.sv
// surf_debug_capture_ram: simple dual-port capture buffer, one write port, registered read.
module surf_debug_capture_ram
    import surf_debug_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = DBG_WIDTH
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read register only advances on re_i so a stalled beat stays put.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/surf_debug_capture.sv
// surf_debug_capture: triggered circular capture of debug words with valid/ready readout.
// Define SURF_DEBUG_CAPTURE_TRIG_MATCH_EN to enable the mask/value match trigger.
module surf_debug_capture
    import surf_debug_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8,
    parameter int WIDTH      = DBG_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [WIDTH-1:0]      dbg_i,
    input  logic                  arm_i,
    input  logic                  trig_i,
    input  logic [WIDTH-1:0]      trig_mask_i,
    input  logic [WIDTH-1:0]      trig_value_i,
    input  logic [DEPTH_LOG2-1:0] post_count_i,
    output logic                  armed_o,
    output logic                  done_o,
    output logic [WIDTH-1:0]      rd_data_o,
    output logic                  rd_valid_o,
    output logic                  rd_last_o,
    input  logic                  rd_ready_i
);

    cap_state_e              state_q;
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0]     fill_q, fill_d;
    logic [DEPTH_LOG2-1:0]   post_cnt_q;
    logic [DEPTH_LOG2:0]     rd_offset_q, rd_offset_d;
    logic                    armed_q, done_q, rd_valid_q, rd_last_q;
    logic                    match, trig_hit, wr_en, rd_en, xfer;
    logic [DEPTH_LOG2-1:0]   rd_base, rd_addr;

`ifdef SURF_DEBUG_CAPTURE_TRIG_MATCH_EN
    assign match = (|trig_mask_i) && ((dbg_i & trig_mask_i) == (trig_value_i & trig_mask_i));
`else
    logic unused_match;
    assign unused_match = ^{trig_mask_i, trig_value_i};
    assign match        = 1'b0;
`endif

    assign trig_hit = trig_i || match;
    assign wr_en    = (state_q == ARMED) || (state_q == POST);
    assign xfer     = rd_valid_q && rd_ready_i;

    // Fill only reaches DEPTH once the buffer has wrapped; then the oldest sample sits at wr_ptr.
    assign rd_base  = fill_q[DEPTH_LOG2] ? wr_ptr_q : '0;
    assign rd_addr  = rd_base + rd_offset_q[DEPTH_LOG2-1:0];
    assign rd_en    = (state_q == DONE) && (rd_offset_q != fill_q) && (!rd_valid_q || rd_ready_i);

    always_comb begin
        wr_ptr_d    = wr_ptr_q + 1'b1;
        fill_d      = fill_q[DEPTH_LOG2] ? fill_q : fill_q + 1'b1;
        rd_offset_d = rd_offset_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            post_cnt_q  <= '0;
            rd_offset_q <= '0;
            armed_q     <= 1'b0;
            done_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arm_i) begin
                        state_q     <= ARMED;
                        armed_q     <= 1'b1;
                        wr_ptr_q    <= '0;
                        fill_q      <= '0;
                        rd_offset_q <= '0;
                    end
                end
                ARMED: begin
                    wr_ptr_q <= wr_ptr_d;
                    fill_q   <= fill_d;
                    if (trig_hit) begin
                        if (post_count_i == '0) begin
                            state_q <= DONE;
                            armed_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= POST;
                            post_cnt_q <= post_count_i;
                        end
                    end
                end
                POST: begin
                    wr_ptr_q   <= wr_ptr_d;
                    fill_q     <= fill_d;
                    post_cnt_q <= post_cnt_q - 1'b1;
                    if (post_cnt_q == DEPTH_LOG2'(1)) begin
                        state_q <= DONE;
                        armed_q <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    if (rd_en) begin
                        rd_offset_q <= rd_offset_d;
                        rd_valid_q  <= 1'b1;
                        rd_last_q   <= (rd_offset_d == fill_q);
                    end else if (xfer) begin
                        rd_valid_q <= 1'b0;
                        rd_last_q  <= 1'b0;
                    end
                    // A new arm outranks everything, including the final beat.
                    if (arm_i) begin
                        state_q     <= ARMED;
                        armed_q     <= 1'b1;
                        done_q      <= 1'b0;
                        rd_valid_q  <= 1'b0;
                        rd_last_q   <= 1'b0;
                        wr_ptr_q    <= '0;
                        fill_q      <= '0;
                        rd_offset_q <= '0;
                    end else if (xfer && rd_last_q) begin
                        state_q    <= IDLE;
                        done_q     <= 1'b0;
                        rd_valid_q <= 1'b0;
                        rd_last_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    surf_debug_capture_ram #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (WIDTH)
    ) u_ram (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (dbg_i),
        .re_i    (rd_en),
        .raddr_i (rd_addr),
        .rdata_o (rd_data_o)
    );

    assign armed_o    = armed_q;
    assign done_o     = done_q;
    assign rd_valid_o = rd_valid_q;
    assign rd_last_o  = rd_last_q;

endmodule

// File: doc/surf_debug_capture.md
SURF_DEBUG_CAPTURE -- requirements
Module: surf_debug_capture

Interface
REQ-001 Parameter: DEPTH_LOG2, 8, log2 of capture buffer depth (DEPTH = 2**DEPTH_LOG2 samples).
REQ-002 Parameter: WIDTH, 35, debug word width; matches the registered debug multiplexer output.
REQ-003 Port: clk_i  input  1  single clock; all logic on rising edge.
REQ-004 Port: rst_n_i  input  1  synchronous, active-low reset.
REQ-005 Port: dbg_i  input  WIDTH  debug word from the debug multiplexer output.
REQ-006 Port: arm_i  input  1  single-cycle arm request.
REQ-007 Port: trig_i  input  1  external trigger, level-sampled.
REQ-008 Port: trig_mask_i  input  WIDTH  match-trigger bit mask.
REQ-009 Port: trig_value_i  input  WIDTH  match-trigger compare value.
REQ-010 Port: post_count_i  input  DEPTH_LOG2  samples written after the trigger sample.
REQ-011 Port: armed_o  output  1  high in ARMED or POST.
REQ-012 Port: done_o  output  1  high in DONE.
REQ-013 Port: rd_data_o  output  WIDTH  readout sample.
REQ-014 Port: rd_valid_o  output  1  rd_data_o valid.
REQ-015 Port: rd_last_o  output  1  current beat is final sample; qualified by rd_valid_o.
REQ-016 Port: rd_ready_i  input  1  readout consumer ready.

Function
REQ-017 States SHALL be IDLE, ARMED, POST, DONE.
REQ-018 IDLE: no buffer writes; arm_i -> ARMED next cycle, wr_ptr := 0, fill := 0.
REQ-019 ARMED: dbg_i written at wr_ptr every cycle, wr_ptr increments mod DEPTH, fill saturates at DEPTH.
REQ-020 Trigger in ARMED = trig_i OR match, match = (mask != 0) AND ((dbg_i & mask) == (value & mask)), evaluated on the same dbg_i being written.
REQ-021 Trigger sample SHALL be written; post_count_i = 0 -> DONE next cycle, else POST with counter := post_count_i.
REQ-022 POST: write every cycle, decrement counter; write with counter = 1 -> DONE; triggers ignored.
REQ-023 arm_i SHALL be ignored in ARMED and POST.
REQ-024 DONE: read start = wr_ptr if fill == DEPTH else 0; beats = fill; oldest first, buffer order.
REQ-025 Readout: valid/ready; beat transfers when rd_valid_o & rd_ready_i; rd_data_o, rd_last_o stable while rd_valid_o & !rd_ready_i.
REQ-026 First rd_valid_o no later than 2 cycles after DONE entry; sustained 1 beat/cycle with rd_ready_i held high.
REQ-027 Transfer with rd_last_o high -> IDLE next cycle; rd_valid_o low that cycle.
REQ-028 arm_i in DONE aborts readout, rd_valid_o low next cycle, enters ARMED as REQ-018.
REQ-029 Simultaneous arm_i and final-beat transfer: arm wins, ARMED next cycle.

Reset
REQ-030 rst_n_i low at a clock edge -> IDLE; armed_o, done_o, rd_valid_o, rd_last_o = 0; rd_data_o = 0; pointers/counters = 0.
REQ-031 Reset mid-capture or mid-readout SHALL behave as REQ-030; buffer contents are not cleared and not readable until next capture.

Configuration
REQ-032 Macro SURF_DEBUG_CAPTURE_TRIG_MATCH_EN defined: match trigger per REQ-020.
REQ-033 Macro undefined: match term constant 0, only trig_i triggers; trig_mask_i and trig_value_i remain as ports, ignored.

Structure
REQ-034 Package surf_debug_pkg SHALL hold DBG_WIDTH = 35 and the capture state enum.
REQ-035 Buffer SHALL be sub-module surf_debug_capture_ram: simple dual-port, one write port, 1-cycle registered read.

Verification (DEPTH_LOG2 = 4)
REQ-036 arm, dbg_i = cycle count, trig_i at sample 5, post_count_i = 3 -> 9 beats 0..8, rd_last_o on 8.
REQ-037 arm, 40 samples 0..39, trig_i at 36, post_count_i = 3 -> 16 beats 24..39.
REQ-038 Macro defined, mask = 0x0000000FF, value = 0x0000000AB, dbg_i = 0xAB at sample 7, post_count_i = 0 -> DONE, 8 beats, last = 0xAB.
REQ-039 Readout with rd_ready_i toggling 1010 -> each beat held stable until accepted, no loss/duplication.
REQ-040 rst_n_i low in POST -> next cycle armed_o = 0, done_o = 0, rd_valid_o = 0; new arm then capture is correct.
REQ-041 Macro undefined, matching dbg_i, trig_i low -> stays ARMED.
